// File: rtl/search_sequencer_if.sv
// Memory read port of the search sequencer: one outstanding read at a time.
// Handshake: mem_req acts as valid and mem_addr is held stable while it is high; mem_ack acts
// as ready/response, and the read completes in the cycle where mem_req && mem_ack, with mem_rdata valid then.
interface search_sequencer_if #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/search_sequencer.sv
// Linear memory search: reads len words from base, compares each against key through an
// external shared equality detector, and reports the first matching address.
module search_sequencer #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     key,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W-1:0]     len,
    search_sequencer_if.master    mem,
    output logic [DATA_W-1:0]     cmp_ac,
    output logic [DATA_W-1:0]     cmp_dr,
    input  logic                  eq,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [ADDR_W-1:0]     match_addr,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CMP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic [ADDR_W-1:0] match_q, match_d;
    logic              found_q, found_d;
    // Zero-length searches spend one extra IDLE cycle so done lands two cycles after start.
    logic              zpend_q, zpend_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            dr_q     <= '0;
            addr_q   <= '0;
            remain_q <= '0;
            match_q  <= '0;
            found_q  <= 1'b0;
            zpend_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            dr_q     <= dr_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            match_q  <= match_d;
            found_q  <= found_d;
            zpend_q  <= zpend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        dr_d     = dr_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        match_d  = match_q;
        found_d  = found_q;
        zpend_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (zpend_q) begin
                    state_d = S_FIN;
                end else if (start) begin
                    found_d = 1'b0;
                    match_d = '0;
                    if (len != '0) begin
                        key_d    = key;
                        addr_d   = base;
                        remain_d = len;
                        state_d  = S_REQ;
                    end else begin
                        zpend_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                // Abort beats a same-cycle ack; the returning word is dropped.
                if (abort) begin
                    found_d = 1'b0;
                    state_d = S_FIN;
                end else if (mem.mem_ack) begin
                    dr_d    = mem.mem_rdata;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (abort) begin
                    found_d = 1'b0;
                    state_d = S_FIN;
                end else if (eq) begin
                    found_d = 1'b1;
                    match_d = addr_q;
                    state_d = S_FIN;
                end else if (remain_q == ADDR_W'(1)) begin
                    state_d = S_FIN;
                end else begin
                    remain_d = remain_q - ADDR_W'(1);
                    addr_d   = addr_q + ADDR_W'(1);
                    state_d  = S_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.mem_req  = (state_q == S_REQ);
    assign mem.mem_addr = addr_q;
    assign cmp_ac       = key_q;
    assign cmp_dr       = dr_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FIN);
    assign found        = found_q;
    assign match_addr   = match_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/search_sequencer.md
SEARCH_SEQUENCER -- requirements
Module: search_sequencer

Interface
REQ-001 Parameter DATA_W, default 19, is the operand width presented to the shared equality detector.
REQ-002 Parameter ADDR_W, default 19, is the memory address width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, asynchronous and active-high.
REQ-005 Port start  input  1  is a one-cycle request to begin a search; it is sampled only in IDLE.
REQ-006 Port abort  input  1  terminates an active search.
REQ-007 Port key  input  DATA_W  is the search value, latched on accepted start.
REQ-008 Port base  input  ADDR_W  is the first address to read, latched on accepted start.
REQ-009 Port len  input  ADDR_W  is the number of words to scan, latched on accepted start.
REQ-010 Port mem_req  output  1  requests a memory read.
REQ-011 Port mem_addr  output  ADDR_W  is the read address.
REQ-012 Port mem_ack  input  1  indicates that mem_rdata is valid this cycle.
REQ-013 Port mem_rdata  input  DATA_W  is the read data.
REQ-014 Port cmp_ac  output  DATA_W  drives the AC operand of the shared equality detector with the latched key.
REQ-015 Port cmp_dr  output  DATA_W  drives the DR operand of the detector with the latched read word.
REQ-016 Port eq  input  1  is the detector result: 1 when cmp_ac equals cmp_dr bit for bit.
REQ-017 Port busy  output  1  is high in every state except IDLE.
REQ-018 Port done  output  1  is a one-cycle completion pulse.
REQ-019 Port found  output  1  reports the result of the last search: 1 means a match.
REQ-020 Port match_addr  output  ADDR_W  is the address of the first matching word.

Function
REQ-021 The FSM SHALL have the states IDLE, REQ, CMP and FIN.
REQ-022 IDLE, on start with len != 0:
  - latch key into cmp_ac, base into the address register, and len into the remain register;
  - clear found and match_addr;
  - go to REQ.
REQ-023 IDLE, on start with len == 0: clear found and match_addr, then go to FIN, so that done pulses exactly 2 cycles after start.
REQ-024 REQ:
  - mem_req=1 and mem_addr=address register, both held stable until mem_ack;
  - on mem_ack, latch mem_rdata into cmp_dr and go to CMP.
REQ-025 CMP (mem_req=0), evaluated on the registered cmp_dr:
  - eq=1: set found=1 and match_addr=address register, go to FIN;
  - eq=0 and remain==1: go to FIN with found=0;
  - eq=0 otherwise: decrement remain, increment the address modulo 2^ADDR_W (0x7FFFF+1 wraps to 0x00000), go to REQ.
REQ-026 FIN SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-027 Abort asserted in REQ or CMP SHALL force FIN with found=0.
REQ-028 Abort SHALL win over a simultaneous mem_ack or eq=1.
REQ-029 A read in flight when abort is taken SHALL be discarded.
REQ-030 Abort in IDLE or FIN SHALL have no effect.
REQ-031 Start outside IDLE SHALL be ignored; start in the same cycle as a FIN-to-IDLE transition is also ignored.
REQ-032 found and match_addr SHALL hold their values from FIN until the next accepted start.
REQ-033 The minimum cost per word is 2 cycles (REQ with immediate ack, then CMP); each additional cycle of mem_ack latency adds one cycle.

Reset
REQ-034 Asserting rst SHALL immediately force the following, regardless of state or any in-flight read:
  - FSM to IDLE;
  - mem_req=0, busy=0, done=0, found=0;
  - mem_addr, match_addr, cmp_ac, cmp_dr and remain to 0.
REQ-035 After rst deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
  - Match: key=0x12345, base=0x00100, len=4, memory[0x102]=0x12345, ack zero-wait -> done after 7 cycles, found=1, match_addr=0x00102.
  - No match: key=0x7FFFF, len=3, no memory word equal -> 3 reads at base..base+2, then done with found=0.
  - Wrap-around: base=0x7FFFE, len=3, match at 0x00000 -> reads at 0x7FFFE, 0x7FFFF, 0x00000; found=1, match_addr=0x00000.
  - Zero length plus start while busy: start with len=0 -> done 2 cycles later with no mem_req; a second start raised mid-search -> no effect on key or addresses.
  - Abort: abort in the same cycle as mem_ack carrying a matching word -> FIN, found=0, done pulses once.
  - Reset mid-operation: rst asserted in REQ with mem_req=1 -> mem_req, busy and found drop asynchronously; a new search then runs normally.
